cmd_issue_queue: RTL and testbench

//  Downstream of the bank arbiter. Buffers arbitrated packet/command pairs and discards ignored ones.

---
 rtl/aimc_lib.sv | 34 +++
 rtl/cmd_issue_queue_fifo.sv | 57 +++++
 rtl/cmd_issue_queue.sv | 140 ++++++++++++++
 tb/tb_cmd_issue_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aimc_lib.sv
// Shared AIMC types: packet metadata, command encoding and issue-queue defaults.
package aimc_lib;

    typedef struct packed {
        logic [3:0] bank;
        logic [1:0] rank;
        logic [7:0] tag;
    } pkt_meta_t;

    typedef enum logic [2:0] {
        NOP1 = 3'd0,
        ACT  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        PRE  = 3'd4,
        REF  = 3'd5,
        NOP2 = 3'd6,
        MRS  = 3'd7
    } cmd_t;

    localparam int unsigned CIQ_DEPTH_DFLT = 8;
    localparam int unsigned CIQ_GAP_DFLT   = 2;

    typedef struct packed {
        pkt_meta_t pkt;
        cmd_t      cmd;
    } ciq_entry_t;

    // A zero gap still needs a 1-bit counter.
    function automatic int unsigned ciq_gap_width(int unsigned gap);
        return (gap == 0) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/cmd_issue_queue_fifo.sv
// Synchronous packet/command storage for cmd_issue_queue; contents flush on reset.
module cmd_fifo
    import aimc_lib::*;
#(
    parameter int unsigned DEPTH = CIQ_DEPTH_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  ciq_entry_t             wr_data,
    input  logic                   rd_en,
    output ciq_entry_t             rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    ciq_entry_t    mem_q [DEPTH];
    ciq_entry_t    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Caller guarantees no write while full and no read while empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/cmd_issue_queue.sv
// Issue queue between bank arbiter and command handler: filtering, backpressure, issue spacing.
// Optional statistics outputs are built when CIQ_STATS_EN is defined.
module cmd_issue_queue
    import aimc_lib::*;
#(
    parameter int unsigned DEPTH   = CIQ_DEPTH_DFLT,
    parameter int unsigned CMD_GAP = CIQ_GAP_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  pkt_meta_t              bkarb_pkt,
    input  cmd_t                   bkarb_cmd,
    input  logic                   bkarb_pkt_valid,
    input  logic                   bkarb_pkt_ignore,
    output logic                   bkarb_en,
    output pkt_meta_t              issue_pkt,
    output cmd_t                   issue_cmd,
    output logic                   issue_valid,
    input  logic                   issue_rdy,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   q_ovf_err
`ifdef CIQ_STATS_EN
    ,
    output logic [31:0]            stat_issued,
    output logic [31:0]            stat_ignored,
    output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = ciq_gap_width(CMD_GAP);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW:0]   EN_LIMIT = (CW + 1)'(DEPTH - 1);

    logic          push_req, push, pop, full, empty;
    logic [CW-1:0] count_q, count_next;
    ciq_entry_t    wr_entry, head;
    logic [GW-1:0] gap_q, gap_d;
    logic          en_q, en_d;
    logic          ovf_q, ovf_d;

    assign push_req    = bkarb_pkt_valid && !bkarb_pkt_ignore;
    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign issue_valid = !empty && (gap_q == '0);
    assign pop         = issue_valid && issue_rdy;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push        = push_req && (!full || pop);

    assign wr_entry.pkt = bkarb_pkt;
    assign wr_entry.cmd = bkarb_cmd;

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count_q)
    );

    // Each outstanding enable may still turn into a push, so it holds a slot in reserve.
    always_comb begin
        count_next = count_q + CW'(push) - CW'(pop);
        en_d       = ({1'b0, count_next} + (CW + 1)'(en_q)) <= EN_LIMIT;
        ovf_d      = ovf_q || (push_req && full && !pop);
        gap_d      = gap_q;
        if (pop) begin
            gap_d = GW'(CMD_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q  <= 1'b0;
            gap_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            gap_q <= gap_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        issue_cmd = NOP1;
        issue_pkt = '0;
        if (issue_valid) begin
            issue_cmd = head.cmd;
            issue_pkt = head.pkt;
        end
    end

    assign bkarb_en  = en_q;
    assign q_count   = count_q;
    assign q_ovf_err = ovf_q;

`ifdef CIQ_STATS_EN
    logic [31:0]   issued_q, issued_d;
    logic [31:0]   ignored_q, ignored_d;
    logic [CW-1:0] max_occ_q, max_occ_d;

    always_comb begin
        issued_d  = issued_q;
        ignored_d = ignored_q;
        max_occ_d = max_occ_q;
        if (pop && (issued_q != '1)) begin
            issued_d = issued_q + 32'd1;
        end
        if (bkarb_pkt_valid && bkarb_pkt_ignore && (ignored_q != '1)) begin
            ignored_d = ignored_q + 32'd1;
        end
        if (count_next > max_occ_q) begin
            max_occ_d = count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            issued_q  <= '0;
            ignored_q <= '0;
            max_occ_q <= '0;
        end else begin
            issued_q  <= issued_d;
            ignored_q <= ignored_d;
            max_occ_q <= max_occ_d;
        end
    end

    assign stat_issued  = issued_q;
    assign stat_ignored = ignored_q;
    assign stat_max_occ = max_occ_q;
`endif

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Bench for cmd_issue_queue: per-cycle vector table, backpressure/overflow/reset sequences,
// and a scoreboard that checks every issued packet/command in order.
module tb_cmd_issue_queue;
    import aimc_lib::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned CMD_GAP = 2;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    pkt_meta_t     bkarb_pkt;
    cmd_t          bkarb_cmd;
    logic          bkarb_pkt_valid;
    logic          bkarb_pkt_ignore;
    logic          bkarb_en;
    pkt_meta_t     issue_pkt;
    cmd_t          issue_cmd;
    logic          issue_valid;
    logic          issue_rdy;
    logic [CW-1:0] q_count;
    logic          q_ovf_err;
`ifdef CIQ_STATS_EN
    logic [31:0]   stat_issued;
    logic [31:0]   stat_ignored;
    logic [CW-1:0] stat_max_occ;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned pkt_seq = 0;
    ciq_entry_t sb_q[$];

    typedef struct {
        logic valid;
        logic ignore;
        logic rdy;
        cmd_t cmd;
        logic exp_iv;
        cmd_t exp_cmd;
        int   exp_cnt;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    cmd_issue_queue #(
        .DEPTH   (DEPTH),
        .CMD_GAP (CMD_GAP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bkarb_pkt        (bkarb_pkt),
        .bkarb_cmd        (bkarb_cmd),
        .bkarb_pkt_valid  (bkarb_pkt_valid),
        .bkarb_pkt_ignore (bkarb_pkt_ignore),
        .bkarb_en         (bkarb_en),
        .issue_pkt        (issue_pkt),
        .issue_cmd        (issue_cmd),
        .issue_valid      (issue_valid),
        .issue_rdy        (issue_rdy),
        .q_count          (q_count),
        .q_ovf_err        (q_ovf_err)
`ifdef CIQ_STATS_EN
        ,
        .stat_issued      (stat_issued),
        .stat_ignored     (stat_ignored),
        .stat_max_occ     (stat_max_occ)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // acc: whether the queue is expected to keep this packet.
    task automatic drive(input logic v, input logic ign, input cmd_t c, input logic acc);
        logic [13:0] raw;
        ciq_entry_t  e;
        raw = 14'(pkt_seq * 37 + 5);
        pkt_seq++;
        e.pkt = raw;
        e.cmd = c;
        bkarb_pkt_valid  = v;
        bkarb_pkt_ignore = ign;
        bkarb_cmd        = c;
        bkarb_pkt        = e.pkt;
        if (v && !ign && acc) sb_q.push_back(e);
    endtask

    function automatic vec_t mk(input logic v, input logic ign, input logic rdy, input cmd_t c,
                                input logic iv, input cmd_t ec, input int cnt);
        vec_t r;
        r.valid   = v;
        r.ignore  = ign;
        r.rdy     = rdy;
        r.cmd     = c;
        r.exp_iv  = iv;
        r.exp_cmd = ec;
        r.exp_cnt = cnt;
        return r;
    endfunction

    // Handshake happens at the following posedge; rst low at that edge cancels it.
    always @(negedge clk) begin
        ciq_entry_t e;
        if (rst && issue_valid && issue_rdy) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_issue", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_cmd", issue_cmd, e.cmd);
                check("sb_pkt", issue_pkt, e.pkt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   mcount;
        logic men;
        logic v;
        int   cn;
        int   k;

        rst              = 1'b0;
        bkarb_pkt_valid  = 1'b0;
        bkarb_pkt_ignore = 1'b0;
        bkarb_cmd        = NOP1;
        bkarb_pkt        = '0;
        issue_rdy        = 1'b0;

        // single push, then four back-to-back pushes with gap 2
        tbl.push_back(mk(1, 0, 1, ACT,  1, ACT,  1));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));
        tbl.push_back(mk(1, 0, 1, RD,   1, RD,   1));
        tbl.push_back(mk(1, 0, 1, WR,   0, NOP1, 1));
        tbl.push_back(mk(1, 0, 1, PRE,  0, NOP1, 2));
        tbl.push_back(mk(1, 0, 1, REF,  1, WR,   3));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 2));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 2));
        tbl.push_back(mk(0, 0, 1, NOP1, 1, PRE,  2));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 1));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 1));
        tbl.push_back(mk(0, 0, 1, NOP1, 1, REF,  1));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));
        // ignored pushes interleaved with normal ones, head held while not ready
        tbl.push_back(mk(1, 1, 0, PRE,  0, NOP1, 0));
        tbl.push_back(mk(1, 0, 0, RD,   1, RD,   1));
        tbl.push_back(mk(1, 1, 0, WR,   1, RD,   1));
        tbl.push_back(mk(1, 0, 0, WR,   1, RD,   2));
        tbl.push_back(mk(0, 0, 0, NOP1, 1, RD,   2));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 1));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 1));
        tbl.push_back(mk(0, 0, 1, NOP1, 1, WR,   1));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));
        tbl.push_back(mk(0, 0, 1, NOP1, 0, NOP1, 0));

        repeat (3) step();
        check("rst_en",    bkarb_en,    0);
        check("rst_iv",    issue_valid, 0);
        check("rst_cmd",   issue_cmd,   NOP1);
        check("rst_pkt",   issue_pkt,   0);
        check("rst_count", q_count,     0);
        check("rst_ovf",   q_ovf_err,   0);

        rst       = 1'b1;
        issue_rdy = 1'b1;
        step();
        check("rel_en",    bkarb_en,    1);
        check("rel_iv",    issue_valid, 0);
        check("rel_cmd",   issue_cmd,   NOP1);
        check("rel_pkt",   issue_pkt,   0);
        check("rel_count", q_count,     0);
        check("rel_ovf",   q_ovf_err,   0);

        foreach (tbl[i]) begin
            issue_rdy = tbl[i].rdy;
            drive(tbl[i].valid, tbl[i].ignore, tbl[i].cmd, 1'b1);
            step();
            check($sformatf("row%0d_iv", i),    issue_valid, tbl[i].exp_iv);
            check($sformatf("row%0d_cmd", i),   issue_cmd,   tbl[i].exp_cmd);
            check($sformatf("row%0d_count", i), q_count,     tbl[i].exp_cnt);
            check($sformatf("row%0d_en", i),    bkarb_en,    1);
        end
`ifdef CIQ_STATS_EN
        check("stat_issued",  stat_issued,  7);
        check("stat_ignored", stat_ignored, 2);
        check("stat_max_occ", stat_max_occ, 3);
`endif

        // arbiter acknowledges every cycle it is enabled; handler stalls
        issue_rdy = 1'b0;
        mcount    = 0;
        men       = 1'b1;
        for (int c = 0; c < 20; c++) begin
            v = bkarb_en;
            drive(v, 1'b0, cmd_t'(3'(c % 5 + 1)), v && (mcount < DEPTH));
            step();
            cn     = mcount + ((v && (mcount < DEPTH)) ? 1 : 0);
            men    = (cn + (men ? 1 : 0)) <= (DEPTH - 1);
            mcount = cn;
            check($sformatf("bp%0d_count", c), q_count,  mcount);
            check($sformatf("bp%0d_en", c),    bkarb_en, men);
            check($sformatf("bp%0d_ovf", c),   q_ovf_err, 0);
        end
        check("bp_full", q_count, DEPTH);
`ifdef CIQ_STATS_EN
        check("stat_max_full", stat_max_occ, DEPTH);
`endif

        // forced push into a full queue without a pop
        drive(1'b1, 1'b0, ACT, 1'b0);
        step();
        check("ovf_set",   q_ovf_err, 1);
        check("ovf_count", q_count,   DEPTH);
        drive(1'b0, 1'b0, NOP1, 1'b0);
        step();
        check("ovf_sticky", q_ovf_err, 1);

        // drain to 5 entries with gap counter at 1, then reset mid-operation
        issue_rdy = 1'b1;
        k = 0;
        while ((q_count != CW'(5)) && (k < 40)) begin
            step();
            k++;
        end
        check("drain_to_5", q_count, 5);
        step();
        check("pre_rst_iv",    issue_valid, 0);
        check("pre_rst_count", q_count,     5);
        rst = 1'b0;
        step();
        sb_q.delete();
        check("mid_rst_count", q_count,     0);
        check("mid_rst_iv",    issue_valid, 0);
        check("mid_rst_en",    bkarb_en,    0);
        check("mid_rst_ovf",   q_ovf_err,   0);
        check("mid_rst_cmd",   issue_cmd,   NOP1);
        check("mid_rst_pkt",   issue_pkt,   0);
`ifdef CIQ_STATS_EN
        check("mid_rst_issued",  stat_issued,  0);
        check("mid_rst_ignored", stat_ignored, 0);
        check("mid_rst_max",     stat_max_occ, 0);
`endif

        // flushed queue restarts cleanly
        rst = 1'b1;
        step();
        check("post_rst_en", bkarb_en, 1);
        drive(1'b1, 1'b0, WR, 1'b1);
        step();
        check("post_rst_iv",    issue_valid, 1);
        check("post_rst_cmd",   issue_cmd,   WR);
        check("post_rst_count", q_count,     1);
        drive(1'b0, 1'b0, NOP1, 1'b0);
        step();
        check("post_rst_drain", q_count,     0);
        check("sb_empty",       sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
